// File: rtl/conv_1x3x3_ctrl.sv
// Sequencer for one conv_1X3X3 engine: loads weights and quantisation params,
// streams one feature-map channel, counts engine outputs, flags timeout/overrun.
module conv_1x3x3_ctrl #(
  parameter int IMG_W         = 12,
  parameter int IMG_H         = 14,
  parameter int ADDR_W        = 8,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              param_rd,
  output logic [3:0]        param_addr,
  input  logic [15:0]       param_data,
  input  logic              pix_avail,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [7:0]        pix_data,
  output logic              conv_valid_in,
  output logic [7:0]        conv_din,
  output logic [7:0]        weight_11,
  output logic [7:0]        weight_12,
  output logic [7:0]        weight_13,
  output logic [7:0]        weight_21,
  output logic [7:0]        weight_22,
  output logic [7:0]        weight_23,
  output logic [7:0]        weight_31,
  output logic [7:0]        weight_32,
  output logic [7:0]        weight_33,
  output logic [7:0]        zero_point,
  output logic [7:0]        relu_zero_point,
  output logic [7:0]        zero_point_Z3,
  output logic [15:0]       scale_M0,
  output logic [3:0]        shift,
  input  logic              conv_valid_out
);

  localparam int unsigned NPARAM = 14;
  localparam int unsigned TMO_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] NPIX_C     = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] LAST_PIX_C = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] EXP_C      = ADDR_W'((IMG_W - 2) * (IMG_H - 2));
  localparam logic [TMO_W-1:0]  TMO_LAST_C = TMO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0]        LD_LAST_C  = 4'(NPARAM);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        ld_cnt_q, ld_cnt_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              prd_dly_q;
  logic [3:0]        paddr_dly_q;
  logic              vin_q;
  logic [7:0]        din_q;
  logic [7:0]        w_q [9];
  logic [7:0]        zp_q, rzp_q, z3_q;
  logic [15:0]       scale_q;
  logic [3:0]        shift_q;

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    pix_cnt_d = pix_cnt_q;
    out_cnt_d = out_cnt_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    param_rd  = 1'b0;
    pix_rd    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d    = 1'b0;
          ld_cnt_d = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        param_rd = (ld_cnt_q < LD_LAST_C);
        ld_cnt_d = ld_cnt_q + 4'd1;
        // Extra cycle after the last read lets the final word be captured.
        if (ld_cnt_q == LD_LAST_C) begin
          ld_cnt_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        pix_rd = pix_avail && (pix_cnt_q < NPIX_C);
        if (pix_rd) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == LAST_PIX_C) state_d = DRAIN;
        end
      end
      DRAIN: begin
        tmo_d = tmo_q + 1'b1;
        if (out_cnt_q == EXP_C) begin
          state_d = DONE;
        end else if (tmo_q == TMO_LAST_C) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        pix_cnt_d = '0;
        out_cnt_d = '0;
        tmo_d     = '0;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == STREAM || state_q == DRAIN) && conv_valid_out) begin
      if (out_cnt_q == EXP_C) err_d = 1'b1;
      else                    out_cnt_d = out_cnt_q + 1'b1;
    end

    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      ld_cnt_d  = '0;
      pix_cnt_d = '0;
      out_cnt_d = '0;
      tmo_d     = '0;
      err_d     = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ld_cnt_q    <= '0;
      pix_cnt_q   <= '0;
      out_cnt_q   <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      prd_dly_q   <= 1'b0;
      paddr_dly_q <= '0;
      vin_q       <= 1'b0;
      din_q       <= '0;
      zp_q        <= '0;
      rzp_q       <= '0;
      z3_q        <= '0;
      scale_q     <= '0;
      shift_q     <= '0;
      for (int unsigned i = 0; i < 9; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      out_cnt_q   <= out_cnt_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      prd_dly_q   <= param_rd & ~abort;
      paddr_dly_q <= param_addr;
      vin_q       <= pix_rd & ~abort;
      din_q       <= conv_din;
      if (prd_dly_q) begin
        case (paddr_dly_q)
          4'd9:    zp_q    <= param_data[7:0];
          4'd10:   scale_q <= param_data;
          4'd11:   shift_q <= param_data[3:0];
          4'd12:   rzp_q   <= param_data[7:0];
          4'd13:   z3_q    <= param_data[7:0];
          default: if (paddr_dly_q < 4'd9) w_q[paddr_dly_q] <= param_data[7:0];
        endcase
      end
    end
  end

  // Pixel RAM data arrives the cycle after the read; pass it straight through.
  assign conv_valid_in   = vin_q;
  assign conv_din        = vin_q ? pix_data : din_q;
  assign param_addr      = param_rd ? ld_cnt_q : '0;
  assign pix_addr        = pix_cnt_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign err             = err_q;
  assign weight_11       = w_q[0];
  assign weight_12       = w_q[1];
  assign weight_13       = w_q[2];
  assign weight_21       = w_q[3];
  assign weight_22       = w_q[4];
  assign weight_23       = w_q[5];
  assign weight_31       = w_q[6];
  assign weight_32       = w_q[7];
  assign weight_33       = w_q[8];
  assign zero_point      = zp_q;
  assign relu_zero_point = rzp_q;
  assign zero_point_Z3   = z3_q;
  assign scale_M0        = scale_q;
  assign shift           = shift_q;

endmodule

// File: tb/tb_conv_1x3x3_ctrl.sv
// Bench for conv_1x3x3_ctrl: RAM and engine models, a per-cycle stream
// checker and directed frames (load, full, backpressure, timeout, overrun, abort, reset).
module tb_conv_1x3x3_ctrl;

  localparam int W    = 12;
  localparam int H    = 14;
  localparam int N    = W * H;
  localparam int EXPN = (W - 2) * (H - 2);
  localparam int TMO  = 64;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic pix_avail = 1'b0, conv_valid_out = 1'b0;
  logic busy, done, err, param_rd, pix_rd, conv_valid_in;
  logic [3:0]  param_addr, shift;
  logic [15:0] param_data = '0, scale_M0;
  logic [7:0]  pix_addr, pix_data = '0, conv_din;
  logic [7:0]  weight_11, weight_12, weight_13, weight_21, weight_22, weight_23;
  logic [7:0]  weight_31, weight_32, weight_33;
  logic [7:0]  zero_point, relu_zero_point, zero_point_Z3;

  int checks = 0, errors = 0;
  logic [15:0] pmem [14];
  logic [7:0]  pixmem [N];

  bit   bp_mode = 1'b0, mon_on = 1'b0;
  int   eng_in = 0, eng_emit = 0, eng_lim = EXPN;
  int   rd_cnt = 0, prd_cnt = 0, vin_cnt = 0, done_cnt = 0;
  logic e_rd = 1'b0, e_ab = 1'b0, e_rst = 1'b1;
  logic [7:0] e_addr = '0, last_din = '0;

  conv_1x3x3_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(8), .DRAIN_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .param_rd(param_rd), .param_addr(param_addr), .param_data(param_data),
    .pix_avail(pix_avail), .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
    .conv_valid_in(conv_valid_in), .conv_din(conv_din),
    .weight_11(weight_11), .weight_12(weight_12), .weight_13(weight_13),
    .weight_21(weight_21), .weight_22(weight_22), .weight_23(weight_23),
    .weight_31(weight_31), .weight_32(weight_32), .weight_33(weight_33),
    .zero_point(zero_point), .relu_zero_point(relu_zero_point),
    .zero_point_Z3(zero_point_Z3), .scale_M0(scale_M0), .shift(shift),
    .conv_valid_out(conv_valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous-read RAMs: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (param_rd) param_data <= pmem[param_addr];
    if (pix_rd)   pix_data   <= pixmem[pix_addr];
  end

  // Engine: one output per fully-windowed pixel, one cycle later, capped at
  // eng_lim; outputs beyond EXPN are emitted on the following idle cycles.
  always @(posedge clk) begin
    conv_valid_out <= 1'b0;
    if (conv_valid_in) begin
      if ((eng_in % W) >= 2 && (eng_in / W) >= 2 && eng_emit < eng_lim) begin
        conv_valid_out <= 1'b1;
        eng_emit++;
      end
      eng_in++;
    end else if (eng_emit >= EXPN && eng_emit < eng_lim) begin
      conv_valid_out <= 1'b1;
      eng_emit++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    pix_avail = bp_mode ? ~pix_avail : 1'b1;
  end

  always @(posedge clk) begin
    e_rd   <= pix_rd;
    e_addr <= pix_addr;
    e_ab   <= abort;
    e_rst  <= rst;
  end

  // Stream checker: each read must be the next pixel index and reappear on
  // conv_din one cycle later; between reads conv_din holds.
  always @(negedge clk) begin
    logic exp_vin;
    if (mon_on) begin
      exp_vin = e_rd && !e_ab && !e_rst;
      chk("conv_valid_in", {31'd0, conv_valid_in}, {31'd0, exp_vin});
      if (exp_vin) begin
        chk("conv_din", {24'd0, conv_din}, {24'd0, pixmem[e_addr]});
        last_din = pixmem[e_addr];
        vin_cnt++;
      end else begin
        if (e_rst) last_din = '0;
        chk("conv_din_hold", {24'd0, conv_din}, {24'd0, last_din});
      end
      if (pix_rd) begin
        chk("pix_addr_order", {24'd0, pix_addr}, rd_cnt);
        chk("pix_rd_needs_avail", {31'd0, pix_avail}, 1);
        rd_cnt++;
      end
      if (param_rd) begin
        chk("param_addr_order", {28'd0, param_addr}, prd_cnt);
        prd_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic launch(input int lim, input bit bp);
    eng_lim = lim; eng_in = 0; eng_emit = 0; bp_mode = bp;
    rd_cnt = 0; prd_cnt = 0; vin_cnt = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input int lim, input bit bp, input bit exp_err, input bit chk_load);
    int n, prd, c, last_c;
    logic err_prev;
    bit got;
    launch(lim, bp);
    chk("busy_in_load", {31'd0, busy}, 1);
    chk("err_cleared_by_start", {31'd0, err}, 0);
    n = 1;
    prd = param_rd ? 1 : 0;
    while (!pix_rd && n < 60) begin
      @(negedge clk);
      n++;
      if (param_rd) prd++;
    end
    chk("param_rd_cycles", prd, 14);
    if (chk_load) begin
      chk("stream_entry_cycle", n, 16);
      chk("weight_11", {24'd0, weight_11}, 1);
      chk("weight_12", {24'd0, weight_12}, 2);
      chk("weight_13", {24'd0, weight_13}, 3);
      chk("weight_21", {24'd0, weight_21}, 4);
      chk("weight_22", {24'd0, weight_22}, 5);
      chk("weight_23", {24'd0, weight_23}, 6);
      chk("weight_31", {24'd0, weight_31}, 7);
      chk("weight_32", {24'd0, weight_32}, 8);
      chk("weight_33", {24'd0, weight_33}, 9);
      chk("zero_point", {24'd0, zero_point}, 0);
      chk("scale_M0", {16'd0, scale_M0}, 99);
      chk("shift", {28'd0, shift}, 1);
      chk("relu_zero_point", {24'd0, relu_zero_point}, 1);
      chk("zero_point_Z3", {24'd0, zero_point_Z3}, 1);
    end
    c = 0; last_c = -1000; err_prev = 1'b0; got = 1'b0;
    while (c < 3000 && !got) begin
      if (pix_rd && pix_addr == 8'(N - 1)) last_c = c;
      if (done) got = 1'b1;
      else begin
        err_prev = err;
        @(negedge clk);
        c++;
      end
    end
    chk("done_seen", {31'd0, got}, 1);
    chk("err_before_done", {31'd0, err_prev}, 0);
    chk("err_at_done", {31'd0, err}, {31'd0, exp_err});
    chk("done_after_last_read", c - last_c, (lim < EXPN) ? TMO + 1 : 4);
    chk("reads_per_frame", rd_cnt, N);
    chk("valid_in_per_frame", vin_cnt, N);
    @(negedge clk);
    chk("busy_falls_after_done", {31'd0, busy}, 0);
    chk("done_one_cycle", {31'd0, done}, 0);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("err_sticky", {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic wait_pix(input int idx);
    int c;
    c = 0;
    while (!(pix_rd && pix_addr == 8'(idx)) && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("reach_pixel", {24'd0, pix_addr}, idx);
  endtask

  task automatic abort_test();
    launch(EXPN, 1'b0);
    wait_pix(50);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_valid_in", {31'd0, conv_valid_in}, 0);
    chk("abort_pix_rd", {31'd0, pix_rd}, 0);
    chk("abort_param_rd", {31'd0, param_rd}, 0);
    chk("abort_pix_addr", {24'd0, pix_addr}, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
  endtask

  task automatic reset_test();
    launch(EXPN, 1'b0);
    wait_pix(30);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_param_rd", {31'd0, param_rd}, 0);
    chk("rst_param_addr", {28'd0, param_addr}, 0);
    chk("rst_pix_rd", {31'd0, pix_rd}, 0);
    chk("rst_pix_addr", {24'd0, pix_addr}, 0);
    chk("rst_valid_in", {31'd0, conv_valid_in}, 0);
    chk("rst_conv_din", {24'd0, conv_din}, 0);
    chk("rst_weight_11", {24'd0, weight_11}, 0);
    chk("rst_weight_33", {24'd0, weight_33}, 0);
    chk("rst_scale_M0", {16'd0, scale_M0}, 0);
    chk("rst_shift", {28'd0, shift}, 0);
    chk("rst_relu_zp", {24'd0, relu_zero_point}, 0);
    chk("rst_zp_Z3", {24'd0, zero_point_Z3}, 0);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) pmem[i] = 16'(i + 1);
    pmem[9] = 16'd0; pmem[10] = 16'd99; pmem[11] = 16'd1;
    pmem[12] = 16'd1; pmem[13] = 16'd1;
    for (int i = 0; i < N; i++) pixmem[i] = 8'((i * 37 + 5) % 256);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_err", {31'd0, err}, 0);
    chk("reset_weight_11", {24'd0, weight_11}, 0);
    chk("reset_scale_M0", {16'd0, scale_M0}, 0);
    chk("reset_pix_addr", {24'd0, pix_addr}, 0);

    run_frame(EXPN,     1'b0, 1'b0, 1'b1);
    run_frame(EXPN,     1'b1, 1'b0, 1'b0);
    run_frame(100,      1'b0, 1'b1, 1'b0);
    run_frame(EXPN + 1, 1'b0, 1'b1, 1'b0);
    abort_test();
    run_frame(EXPN,     1'b0, 1'b0, 1'b1);
    reset_test();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
